// File: rtl/ahb_mem_slave.sv
// rtl/ahb_mem_slave.sv - AHB-Lite-style doubleword memory responder with wait states and error response
module ahb_mem_slave #(
    parameter logic [63:0] BASE_ADDR   = 64'h0,
    parameter int          DEPTH_LOG2  = 9,
    parameter int          WAIT_STATES = 0
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        HSEL,
    input  logic        HTRANS,
    input  logic [63:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [63:0] HWDATA,
    output logic [63:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP
);

    localparam int          DEPTH = 1 << DEPTH_LOG2;
    localparam logic [2:0]  WS    = 3'(WAIT_STATES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t r_state;
    state_t w_next;
    state_t w_acc_target;

    logic [63:0]           r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_index;
    logic [2:0]            r_lane;
    logic [1:0]            r_size;
    logic                  r_write;
    logic [2:0]            r_wcnt;
    logic [63:0]           r_hrdata;

    logic [63:0]           w_offset;
    logic [DEPTH_LOG2-1:0] w_acc_index;
    logic [2:0]            w_acc_lane;
    logic                  w_out_of_range;
    logic                  w_misaligned;
    logic                  w_acc_err;
    logic                  w_req;
    logic                  w_accept;

    logic                  w_commit;
    logic [63:0]           w_wr_mask;
    logic [63:0]           w_wr_merged;

    logic                  w_rd_from_acc;
    logic                  w_rd_from_wait;
    logic                  w_hrdata_load;
    logic [DEPTH_LOG2-1:0] w_rd_index;
    logic [2:0]            w_rd_lane;
    logic [1:0]            w_rd_size;
    logic [63:0]           w_rd_word;
    logic [63:0]           w_rd_data;

    function automatic logic [63:0] f_size_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 64'h0000_0000_0000_00FF;
            2'd1:    return 64'h0000_0000_0000_FFFF;
            2'd2:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    // Address-phase decode; addresses below BASE_ADDR wrap to large offsets and fail the range test.
    assign w_offset       = HADDR - BASE_ADDR;
    assign w_acc_index    = w_offset[DEPTH_LOG2+2:3];
    assign w_acc_lane     = w_offset[2:0];
    assign w_out_of_range = |w_offset[63:DEPTH_LOG2+3];

    always_comb begin
        w_misaligned = 1'b1;
        case (HSIZE)
            3'd0:    w_misaligned = 1'b0;
            3'd1:    w_misaligned = w_acc_lane[0];
            3'd2:    w_misaligned = |w_acc_lane[1:0];
            3'd3:    w_misaligned = |w_acc_lane;
            default: w_misaligned = 1'b1;   // sizes above a doubleword cannot be served
        endcase
    end

    assign w_acc_err    = w_out_of_range | w_misaligned;
    assign w_req        = HSEL & HTRANS;
    assign w_accept     = w_req & HREADY;
    assign w_acc_target = w_acc_err ? S_ERR1 : ((WAIT_STATES > 0) ? S_WAIT : S_DATA);

    always_comb begin
        w_next = r_state;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) w_next = w_acc_target;
            end
            S_WAIT: begin
                HREADY = 1'b0;
                if (r_wcnt == 3'd1) w_next = S_DATA;
            end
            S_DATA: begin
                w_next = w_req ? w_acc_target : S_IDLE;
            end
            S_ERR1: begin
                HREADY = 1'b0;
                HRESP  = 1'b1;
                w_next = S_ERR2;
            end
            S_ERR2: begin
                HRESP  = 1'b1;
                w_next = w_req ? w_acc_target : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_commit    = (r_state == S_DATA) & r_write;
    assign w_wr_mask   = f_size_mask(r_size) << {r_lane, 3'b000};
    assign w_wr_merged = (r_mem[r_index] & ~w_wr_mask) | ((HWDATA << {r_lane, 3'b000}) & w_wr_mask);

    // Read data is captured on the edge that enters DATA: straight from the accept with no
    // wait states, or from the latched address at the end of the wait count.
    assign w_rd_from_acc  = w_accept & ~w_acc_err & ~HWRITE & (WAIT_STATES == 0);
    assign w_rd_from_wait = (r_state == S_WAIT) & (r_wcnt == 3'd1) & ~r_write;
    assign w_hrdata_load  = w_rd_from_acc | w_rd_from_wait;

    assign w_rd_index = (r_state == S_WAIT) ? r_index : w_acc_index;
    assign w_rd_lane  = (r_state == S_WAIT) ? r_lane  : w_acc_lane;
    assign w_rd_size  = (r_state == S_WAIT) ? r_size  : HSIZE[1:0];

    // A write committing this edge to the same doubleword must be visible to a back-to-back read.
    assign w_rd_word = (w_commit && (r_index == w_rd_index)) ? w_wr_merged : r_mem[w_rd_index];
    assign w_rd_data = (w_rd_word >> {w_rd_lane, 3'b000}) & f_size_mask(w_rd_size);

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_index  <= '0;
            r_lane   <= '0;
            r_size   <= '0;
            r_write  <= 1'b0;
            r_wcnt   <= '0;
            r_hrdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_index <= w_acc_index;
                r_lane  <= w_acc_lane;
                r_size  <= HSIZE[1:0];
                r_write <= HWRITE & ~w_acc_err;
                r_wcnt  <= WS;
            end else if (r_state == S_WAIT) begin
                r_wcnt <= r_wcnt - 3'd1;
            end
            if (w_hrdata_load) r_hrdata <= w_rd_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset && w_commit) r_mem[r_index] <= w_wr_merged;
    end

    assign HRDATA = r_hrdata;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// tb/tb_ahb_mem_slave.sv - self-checking bench for ahb_mem_slave with byte-level reference model
module tb_ahb_mem_slave;

    localparam logic [63:0] BASE3    = 64'h8000_0000;
    localparam logic [63:0] MEM_SIZE = 64'd4096;

    typedef struct {
        bit          wr;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
    } xfer_t;

    logic        CLK = 1'b0;
    logic        reset;
    logic        HSEL0, HSEL3, HTRANS, HWRITE;
    logic [63:0] HADDR, HWDATA;
    logic [2:0]  HSIZE;
    logic [63:0] HRDATA0, HRDATA3;
    logic        HREADY0, HREADY3, HRESP0, HRESP3;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [7:0]  mdl [2][256];
    logic [63:0] last_rd [2];

    always #5 CLK = ~CLK;

    ahb_mem_slave #(.BASE_ADDR(64'h0), .DEPTH_LOG2(9), .WAIT_STATES(0)) u_dut0 (
        .CLK(CLK), .reset(reset), .HSEL(HSEL0), .HTRANS(HTRANS), .HADDR(HADDR),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HRDATA(HRDATA0), .HREADY(HREADY0), .HRESP(HRESP0)
    );

    ahb_mem_slave #(.BASE_ADDR(BASE3), .DEPTH_LOG2(9), .WAIT_STATES(3)) u_dut3 (
        .CLK(CLK), .reset(reset), .HSEL(HSEL3), .HTRANS(HTRANS), .HADDR(HADDR),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HRDATA(HRDATA3), .HREADY(HREADY3), .HRESP(HRESP3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic xfer_t mk(input bit wr, input logic [63:0] addr, input logic [2:0] size,
                                 input logic [63:0] wdata);
        xfer_t x;
        x.wr = wr; x.addr = addr; x.size = size; x.wdata = wdata;
        return x;
    endfunction

    function automatic logic rdy(input int d);
        return (d != 0) ? HREADY3 : HREADY0;
    endfunction

    function automatic logic rsp(input int d);
        return (d != 0) ? HRESP3 : HRESP0;
    endfunction

    function automatic logic [63:0] rdat(input int d);
        return (d != 0) ? HRDATA3 : HRDATA0;
    endfunction

    function automatic logic [63:0] base_of(input int d);
        return (d != 0) ? BASE3 : 64'h0;
    endfunction

    function automatic int ws_of(input int d);
        return (d != 0) ? 3 : 0;
    endfunction

    function automatic bit m_err(input int d, input logic [63:0] addr, input logic [2:0] size);
        logic [63:0] off;
        off = addr - base_of(d);
        if (size > 3'd3) return 1'b1;
        return (off >= MEM_SIZE) || ((off % (64'd1 << size)) != 64'd0);
    endfunction

    // Reference: memory as a flat byte array, transfers applied in bus order.
    task automatic model_xfer(input int d, input xfer_t x, output bit err, output logic [63:0] rd);
        int o;
        int n;
        err = m_err(d, x.addr, x.size);
        rd  = last_rd[d];
        if (!err) begin
            o = int'(x.addr - base_of(d));
            n = 1 << x.size;
            if (x.wr) begin
                for (int b = 0; b < n; b++) mdl[d][o+b] = x.wdata[8*b +: 8];
            end else begin
                rd = 64'h0;
                for (int b = 0; b < n; b++) rd[8*b +: 8] = mdl[d][o+b];
                last_rd[d] = rd;
            end
        end
    endtask

    task automatic drive_addr(input int d, input xfer_t x);
        HSEL0  = (d == 0);
        HSEL3  = (d != 0);
        HTRANS = 1'b1;
        HADDR  = x.addr;
        HWRITE = x.wr;
        HSIZE  = x.size;
    endtask

    task automatic drive_idle();
        HSEL0  = 1'b0;
        HSEL3  = 1'b0;
        HTRANS = 1'b0;
    endtask

    // Single transfer with idle cycles around it; works for any wait-state count and errors.
    task automatic xfer(input int d, input xfer_t x, input string tag);
        bit          err;
        logic [63:0] exp;
        int          waits;
        model_xfer(d, x, err, exp);
        drive_addr(d, x);
        step();
        drive_idle();
        HWDATA = x.wdata;
        waits  = 0;
        while (!rdy(d) && waits < 20) begin
            check({tag, ":wait_resp"}, 64'(rsp(d)), 64'(err));
            waits++;
            step();
        end
        check({tag, ":waits"}, 64'(waits), err ? 64'd1 : 64'(ws_of(d)));
        check({tag, ":resp"}, 64'(rsp(d)), 64'(err));
        check({tag, ":rdata"}, rdat(d), exp);
        step();
    endtask

    // Back-to-back OKAY transfers on the zero-wait-state instance, one per cycle.
    task automatic pipe0(input xfer_t q[$], input string tag);
        bit          err;
        logic [63:0] exp;
        for (int i = 0; i <= q.size(); i++) begin
            if (i < q.size()) drive_addr(0, q[i]);
            else drive_idle();
            if (i > 0) HWDATA = q[i-1].wdata;
            step();
            if (i < q.size()) begin
                model_xfer(0, q[i], err, exp);
                check({tag, ":ready"}, 64'(HREADY0), 64'd1);
                check({tag, ":resp"}, 64'(HRESP0), 64'(err));
                check({tag, ":rdata"}, HRDATA0, exp);
            end
        end
    endtask

    function automatic xfer_t rand_xfer(input int d, input int span);
        logic [2:0]  size;
        logic [63:0] off;
        int          mode;
        size = 3'($urandom_range(0, 3));
        off  = 64'($urandom_range(0, span - 1)) & ~((64'd1 << size) - 64'd1);
        mode = $urandom_range(0, 9);
        if (mode == 8 && size != 3'd0) off = off + 64'd1;
        if (mode == 9) off = MEM_SIZE + 64'($urandom_range(0, 4095));
        return mk(1'($urandom_range(0, 1)), base_of(d) + off, size, {$urandom(), $urandom()});
    endfunction

    initial begin
        xfer_t q[$];
        xfer_t x;
        int    d;

        reset  = 1'b0;
        HWDATA = 64'h0;
        HADDR  = 64'h0;
        HWRITE = 1'b0;
        HSIZE  = 3'd0;
        drive_idle();
        last_rd[0] = 64'h0;
        last_rd[1] = 64'h0;
        step(); step(); step();
        check("rst_ready0", 64'(HREADY0), 64'd1);
        check("rst_resp0", 64'(HRESP0), 64'd0);
        check("rst_rdata0", HRDATA0, 64'h0);
        check("rst_ready3", 64'(HREADY3), 64'd1);
        check("rst_rdata3", HRDATA3, 64'h0);
        reset = 1'b1;
        step();

        q.delete();
        for (int i = 0; i < 32; i++) begin
            if (i == 0)      x = mk(1'b1, 64'h0, 3'd3, 64'h1111_2222_3333_4444);
            else if (i == 1) x = mk(1'b1, 64'h8, 3'd3, 64'h5555_6666_7777_8888);
            else if (i == 2) x = mk(1'b1, 64'h10, 3'd3, 64'hAAAA_BBBB_CCCC_DDDD);
            else             x = mk(1'b1, 64'(i * 8), 3'd3, {$urandom(), $urandom()});
            q.push_back(x);
        end
        pipe0(q, "preload0");
        for (int i = 0; i < 32; i++)
            xfer(1, mk(1'b1, BASE3 + 64'(i * 8), 3'd3, {$urandom(), $urandom()}), "preload3");

        // Reset with an active write request: nothing may be committed.
        drive_addr(0, mk(1'b1, 64'h0, 3'd3, 64'h0));
        HWDATA = 64'hBAD0_BAD0_BAD0_BAD0;
        reset  = 1'b0;
        step(); step();
        drive_idle();
        reset = 1'b1;
        last_rd[0] = 64'h0;
        last_rd[1] = 64'h0;
        step();
        check("rst2_ready", 64'(HREADY0), 64'd1);
        check("rst2_resp", 64'(HRESP0), 64'd0);
        check("rst2_rdata", HRDATA0, 64'h0);
        xfer(0, mk(1'b0, 64'h0, 3'd3, 64'h0), "rst2_readback");
        check("rst2_mem0", HRDATA0, 64'h1111_2222_3333_4444);

        q.delete();
        q.push_back(mk(1'b0, 64'h0, 3'd3, 64'h0));
        q.push_back(mk(1'b0, 64'h4, 3'd2, 64'h0));
        q.push_back(mk(1'b0, 64'h8, 3'd3, 64'h0));
        pipe0(q, "b2b_read");
        check("b2b_last", HRDATA0, 64'h5555_6666_7777_8888);

        q.delete();
        q.push_back(mk(1'b1, 64'h10, 3'd2, 64'h0000_0000_DEAD_BEEF));
        q.push_back(mk(1'b0, 64'h10, 3'd3, 64'h0));
        pipe0(q, "fwd");
        check("fwd_data", HRDATA0, 64'hAAAA_BBBB_DEAD_BEEF);

        xfer(1, mk(1'b0, BASE3 + 64'h18, 3'd3, 64'h0), "ws3_read");

        xfer(0, mk(1'b0, 64'h1000, 3'd3, 64'h0), "err_range");
        xfer(0, mk(1'b1, 64'h3, 3'd1, 64'hFFFF), "err_half");
        xfer(0, mk(1'b0, 64'h6, 3'd2, 64'h0), "err_word");
        xfer(0, mk(1'b0, 64'h0, 3'd3, 64'h0), "err_unchanged");
        check("err_mem0", HRDATA0, 64'h1111_2222_3333_4444);
        xfer(1, mk(1'b0, BASE3 - 64'h8, 3'd3, 64'h0), "err_below_base");

        HSEL0 = 1'b0; HSEL3 = 1'b0; HTRANS = 1'b1; HADDR = 64'h1000;
        step();
        check("nosel_ready", 64'(HREADY0), 64'd1);
        check("nosel_resp", 64'(HRESP0), 64'd0);
        HSEL0 = 1'b1; HTRANS = 1'b0;
        step();
        check("notrans_ready", 64'(HREADY0), 64'd1);
        check("notrans_resp", 64'(HRESP0), 64'd0);
        drive_idle();
        step();

        // Reset in the middle of a wait-stated write: the write must be dropped.
        drive_addr(1, mk(1'b1, BASE3 + 64'h20, 3'd3, 64'h0));
        step();
        drive_idle();
        HWDATA = 64'h0123_4567_89AB_CDEF;
        step();
        check("wrst_in_wait", 64'(HREADY3), 64'd0);
        reset = 1'b0;
        step(); step();
        reset = 1'b1;
        last_rd[0] = 64'h0;
        last_rd[1] = 64'h0;
        step();
        check("wrst_ready", 64'(HREADY3), 64'd1);
        check("wrst_resp", 64'(HRESP3), 64'd0);
        check("wrst_rdata", HRDATA3, 64'h0);
        xfer(1, mk(1'b0, BASE3 + 64'h20, 3'd3, 64'h0), "wrst_readback");

        for (int k = 0; k < 40; k++) begin
            q.delete();
            for (int j = 0; j < $urandom_range(1, 6); j++) begin
                x = rand_xfer(0, 64);
                while (m_err(0, x.addr, x.size)) x = rand_xfer(0, 64);
                q.push_back(x);
            end
            pipe0(q, "rnd_pipe");
            if ($urandom_range(0, 1) == 1) step();
        end

        for (int k = 0; k < 40; k++) begin
            d = $urandom_range(0, 1);
            xfer(d, rand_xfer(d, 256), "rnd_xfer");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
